iss_issue_arbiter: RTL and testbench

Single-issue-slot arbiter for the issue stage. Each cycle it picks at most one instruction to issue: either the oldest ready Issue Queue (IQ) entry or the Load/Store Queue (LSQ) head. It replaces the free-running IQ/LSQ priority toggle with three things: IQ-first priority, a bounded LSQ starvation counter, and a memory-port occupancy window. It sits between the IQ/LSQ storage and the register-read/execute pipeline and drives their pop strobes and the `Valid_Instruction`/`Mem_Instruction` qualifiers.

---
 rtl/iss_pkg.sv | 18 +
 rtl/iss_prio_enc.sv | 27 ++
 rtl/iss_issue_arbiter.sv | 111 +++++++++++
 tb/tb_iss_issue_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/iss_pkg.sv
// Shared issue-stage types and sizing constants.
package iss_pkg;

    localparam int unsigned IQ_ENTRIES = 16;
    localparam int unsigned IQ_IDX_W   = $clog2(IQ_ENTRIES);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IQ   = 2'd1,
        GNT_LSQ  = 2'd2
    } gntSrc_t;

    typedef enum logic {
        MEM_FREE = 1'b0,
        MEM_BUSY = 1'b1
    } memState_t;

endpackage

// File: rtl/iss_prio_enc.sv
// Find-first-set: lowest set request bit as one-hot, index and any flag.
module iss_prio_enc #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] reqVec,
    output logic [WIDTH-1:0] oneHot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the top so the lowest set bit is written last and wins.
    always_comb begin
        oneHot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (reqVec[i]) begin
                oneHot    = '0;
                oneHot[i] = 1'b1;
                idx       = IDX_W'(i);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iss_issue_arbiter.sv
// Single issue slot arbiter: IQ-first priority, bounded LSQ starvation and memory-port occupancy window.
module iss_issue_arbiter #(
    parameter int unsigned IQ_ENTRIES      = iss_pkg::IQ_ENTRIES,
    parameter int unsigned STARVE_LIMIT    = 4,
    parameter int unsigned MEM_BUSY_CYCLES = 2
) (
    input  logic                                  CLK,
    input  logic                                  RESET,
    input  logic                                  FREEZE,
    input  logic                                  FLUSH_IN,
    input  logic [IQ_ENTRIES-1:0]                 IQ_ready_IN,
    input  logic                                  LSQ_ready_IN,
    output logic [IQ_ENTRIES-1:0]                 IQ_grant_OUT,
    output logic [$clog2(IQ_ENTRIES)-1:0]         IQ_grantIdx_OUT,
    output logic                                  IQ_pop_OUT,
    output logic                                  LSQ_pop_OUT,
    output logic                                  Valid_Instruction,
    output logic                                  Mem_Instruction,
    output logic [$clog2(STARVE_LIMIT+1)-1:0]     starve_cnt_OUT
);

    import iss_pkg::*;

    localparam int unsigned IDX_W    = $clog2(IQ_ENTRIES);
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned MEM_W    = (MEM_BUSY_CYCLES > 1) ? $clog2(MEM_BUSY_CYCLES) : 1;

    logic [IQ_ENTRIES-1:0] iqOneHot;
    logic [IDX_W-1:0]      iqSel;
    logic                  iqAny;

    memState_t             memState;
    logic [MEM_W-1:0]      memCnt;
    logic [STARVE_W-1:0]   starveCnt;

    logic                  memFree;
    logic                  lsqElig;
    logic                  forceLsq;
    gntSrc_t               gntSrc;

    iss_prio_enc #(
        .WIDTH (IQ_ENTRIES),
        .IDX_W (IDX_W)
    ) uIqEnc (
        .reqVec (IQ_ready_IN),
        .oneHot (iqOneHot),
        .idx    (iqSel),
        .any    (iqAny)
    );

    assign memFree  = (memState == MEM_FREE);
    assign lsqElig  = LSQ_ready_IN & memFree;
    assign forceLsq = (starveCnt >= STARVE_W'(STARVE_LIMIT));

    // Same-cycle grant decision; reset, freeze and flush all suppress issue.
    always_comb begin
        gntSrc = GNT_NONE;
        if (!(RESET || FREEZE || FLUSH_IN)) begin
            if (lsqElig && (!iqAny || forceLsq)) begin
                gntSrc = GNT_LSQ;
            end else if (iqAny) begin
                gntSrc = GNT_IQ;
            end
        end
    end

    assign IQ_pop_OUT        = (gntSrc == GNT_IQ);
    assign LSQ_pop_OUT       = (gntSrc == GNT_LSQ);
    assign IQ_grant_OUT      = IQ_pop_OUT ? iqOneHot : '0;
    assign IQ_grantIdx_OUT   = IQ_pop_OUT ? iqSel : '0;
    assign Valid_Instruction = IQ_pop_OUT | LSQ_pop_OUT;
    assign Mem_Instruction   = LSQ_pop_OUT;
    assign starve_cnt_OUT    = starveCnt;

    // Starvation counter and memory-port window; flush clears even under freeze.
    always_ff @(posedge CLK) begin
        if (RESET || FLUSH_IN) begin
            starveCnt <= '0;
            memCnt    <= '0;
            memState  <= MEM_FREE;
        end else if (!FREEZE) begin
            if (gntSrc == GNT_LSQ) begin
                starveCnt <= '0;
            end else if (lsqElig && (gntSrc == GNT_IQ) && !forceLsq) begin
                starveCnt <= starveCnt + STARVE_W'(1);
            end

            case (memState)
                MEM_FREE: begin
                    if ((gntSrc == GNT_LSQ) && (MEM_BUSY_CYCLES > 1)) begin
                        memState <= MEM_BUSY;
                        memCnt   <= MEM_W'(MEM_BUSY_CYCLES - 1);
                    end
                end
                MEM_BUSY: begin
                    if (memCnt <= MEM_W'(1)) begin
                        memState <= MEM_FREE;
                        memCnt   <= '0;
                    end else begin
                        memCnt <= memCnt - MEM_W'(1);
                    end
                end
                default: begin
                    memState <= MEM_FREE;
                    memCnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iss_issue_arbiter.sv
// Directed bench: dutA uses defaults, dutB uses a 3-cycle memory window; both share stimulus.
module tb_iss_issue_arbiter;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        FREEZE = 1'b0;
    logic        FLUSH_IN = 1'b0;
    logic [15:0] IQ_ready_IN = '0;
    logic        LSQ_ready_IN = 1'b0;

    logic [15:0] aGrant, bGrant;
    logic [3:0]  aIdx, bIdx;
    logic        aIqPop, aLsqPop, aValid, aMem;
    logic        bIqPop, bLsqPop, bValid, bMem;
    logic [2:0]  aStarve, bStarve;

    int vecCnt = 0;
    int errCnt = 0;

    always #5 CLK = ~CLK;

    iss_issue_arbiter dutA (
        .CLK (CLK), .RESET (RESET), .FREEZE (FREEZE), .FLUSH_IN (FLUSH_IN),
        .IQ_ready_IN (IQ_ready_IN), .LSQ_ready_IN (LSQ_ready_IN),
        .IQ_grant_OUT (aGrant), .IQ_grantIdx_OUT (aIdx), .IQ_pop_OUT (aIqPop),
        .LSQ_pop_OUT (aLsqPop), .Valid_Instruction (aValid), .Mem_Instruction (aMem),
        .starve_cnt_OUT (aStarve)
    );

    iss_issue_arbiter #(.MEM_BUSY_CYCLES (3)) dutB (
        .CLK (CLK), .RESET (RESET), .FREEZE (FREEZE), .FLUSH_IN (FLUSH_IN),
        .IQ_ready_IN (IQ_ready_IN), .LSQ_ready_IN (LSQ_ready_IN),
        .IQ_grant_OUT (bGrant), .IQ_grantIdx_OUT (bIdx), .IQ_pop_OUT (bIqPop),
        .LSQ_pop_OUT (bLsqPop), .Valid_Instruction (bValid), .Mem_Instruction (bMem),
        .starve_cnt_OUT (bStarve)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1; FREEZE = 1'b0; FLUSH_IN = 1'b0;
        IQ_ready_IN = '0; LSQ_ready_IN = 1'b0;
        step();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; IQ_ready_IN = 16'hFFFF; LSQ_ready_IN = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #2;
            vecCnt++;
            if ({aIqPop, aLsqPop, aValid, aMem, aGrant, aIdx} !== '0) begin
                errCnt++;
                $display("FAIL reset_outs_A c=%0d got grant=%h idx=%0d pops=%b%b valid=%b mem=%b, want all 0",
                         c, aGrant, aIdx, aIqPop, aLsqPop, aValid, aMem);
            end
            vecCnt++;
            if ({bIqPop, bLsqPop, bValid, bMem, bGrant, bIdx} !== '0) begin
                errCnt++;
                $display("FAIL reset_outs_B c=%0d got grant=%h idx=%0d pops=%b%b, want all 0",
                         c, bGrant, bIdx, bIqPop, bLsqPop);
            end
            step();
        end
        RESET = 1'b0;
        #2;
        vecCnt++;
        if (aStarve !== 3'd0) begin
            errCnt++; $display("FAIL reset_starve got %0d want 0", aStarve);
        end
        vecCnt++;
        if (aGrant !== 16'h0001 || aIdx !== 4'd0 || aIqPop !== 1'b1 || aLsqPop !== 1'b0) begin
            errCnt++;
            $display("FAIL reset_release got grant=%h idx=%0d iqPop=%b lsqPop=%b want 0001/0/1/0",
                     aGrant, aIdx, aIqPop, aLsqPop);
        end
    endtask

    task automatic test_oldest_first();
        do_reset();
        IQ_ready_IN = 16'h0024; LSQ_ready_IN = 1'b0;
        #2;
        vecCnt++;
        if (aIdx !== 4'd2 || aIqPop !== 1'b1 || aGrant !== 16'h0004) begin
            errCnt++;
            $display("FAIL oldest_first got idx=%0d pop=%b grant=%h want 2/1/0004", aIdx, aIqPop, aGrant);
        end
        vecCnt++;
        if (aValid !== 1'b1 || aLsqPop !== 1'b0 || aMem !== 1'b0) begin
            errCnt++;
            $display("FAIL oldest_first_quals got valid=%b lsq=%b mem=%b want 1/0/0", aValid, aLsqPop, aMem);
        end
    endtask

    task automatic test_starvation();
        do_reset();
        IQ_ready_IN = 16'h0001; LSQ_ready_IN = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #2;
            vecCnt++;
            if (aStarve !== 3'(c)) begin
                errCnt++; $display("FAIL starve_cnt c=%0d got %0d want %0d", c, aStarve, c);
            end
            vecCnt++;
            if (aIqPop !== (c < 4) || aLsqPop !== (c == 4)) begin
                errCnt++;
                $display("FAIL starve_grant c=%0d got iq=%b lsq=%b want iq=%b lsq=%b",
                         c, aIqPop, aLsqPop, c < 4, c == 4);
            end
            step();
        end
        #2;
        vecCnt++;
        if (aStarve !== 3'd0 || aIqPop !== 1'b1) begin
            errCnt++; $display("FAIL starve_clear got cnt=%0d iq=%b want 0/1", aStarve, aIqPop);
        end
    endtask

    task automatic test_mem_window();
        do_reset();
        IQ_ready_IN = '0; LSQ_ready_IN = 1'b1;
        for (int c = 0; c < 9; c++) begin
            #2;
            vecCnt++;
            if (bLsqPop !== (c % 3 == 0) || bMem !== (c % 3 == 0) || bValid !== (c % 3 == 0)) begin
                errCnt++;
                $display("FAIL mem_window c=%0d got lsq=%b mem=%b valid=%b want %b",
                         c, bLsqPop, bMem, bValid, c % 3 == 0);
            end
            step();
        end
    endtask

    task automatic test_freeze();
        // Freeze inside the memory window: remaining busy cycles must survive.
        do_reset();
        IQ_ready_IN = '0; LSQ_ready_IN = 1'b1;
        #2;
        vecCnt++;
        if (bLsqPop !== 1'b1) begin
            errCnt++; $display("FAIL freeze_first_grant got %b want 1", bLsqPop);
        end
        step();
        FREEZE = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2;
            vecCnt++;
            if ({aValid, bValid, aLsqPop, bLsqPop, aIqPop, bIqPop} !== 6'b0) begin
                errCnt++;
                $display("FAIL freeze_no_grant c=%0d got A valid=%b B valid=%b want 0", c, aValid, bValid);
            end
            step();
        end
        FREEZE = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            vecCnt++;
            if (bLsqPop !== (c == 2)) begin
                errCnt++; $display("FAIL freeze_resume_B c=%0d got %b want %b", c, bLsqPop, c == 2);
            end
            vecCnt++;
            if (aLsqPop !== (c == 1)) begin
                errCnt++; $display("FAIL freeze_resume_A c=%0d got %b want %b", c, aLsqPop, c == 1);
            end
            step();
        end
        // Freeze with a nonzero starvation count: it must hold.
        do_reset();
        IQ_ready_IN = 16'h0001; LSQ_ready_IN = 1'b1;
        step(); step();
        FREEZE = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2;
            vecCnt++;
            if (aStarve !== 3'd2 || aIqPop !== 1'b0) begin
                errCnt++; $display("FAIL freeze_starve c=%0d got cnt=%0d iq=%b want 2/0", c, aStarve, aIqPop);
            end
            step();
        end
        FREEZE = 1'b0;
        step();
        #2;
        vecCnt++;
        if (aStarve !== 3'd3) begin
            errCnt++; $display("FAIL freeze_starve_resume got %0d want 3", aStarve);
        end
    endtask

    task automatic test_reset_flush_mid_window();
        for (int mode = 0; mode < 3; mode++) begin
            do_reset();
            IQ_ready_IN = '0; LSQ_ready_IN = 1'b1;
            #2;
            vecCnt++;
            if (bLsqPop !== 1'b1) begin
                errCnt++; $display("FAIL midwin_grant mode=%0d got %b want 1", mode, bLsqPop);
            end
            step();
            if (mode == 0) RESET = 1'b1;
            else if (mode == 1) FLUSH_IN = 1'b1;
            else begin FLUSH_IN = 1'b1; FREEZE = 1'b1; end
            #2;
            vecCnt++;
            if (bValid !== 1'b0 || aValid !== 1'b0) begin
                errCnt++; $display("FAIL midwin_suppress mode=%0d got A=%b B=%b want 0", mode, aValid, bValid);
            end
            step();
            RESET = 1'b0; FLUSH_IN = 1'b0; FREEZE = 1'b0;
            #2;
            vecCnt++;
            if (bLsqPop !== 1'b1 || bStarve !== 3'd0) begin
                errCnt++;
                $display("FAIL midwin_regrant mode=%0d got lsq=%b starve=%0d want 1/0", mode, bLsqPop, bStarve);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_oldest_first();
        test_starvation();
        test_mem_window();
        test_freeze();
        test_reset_flush_mid_window();
        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
